// File: rtl/rp_acq_bram_rd.sv
// rp_acq_bram_rd: burst read agent for the acquisition sample buffer.
// One request in flight at a time; samples leave through a 2-entry valid/ready buffer.
module rp_acq_bram_rd #(
    parameter int DW   = 14,
    parameter int RSZ  = 14,
    parameter int TOUT = 15
) (
    input  logic           adc_clk_i,
    input  logic           adc_rstn_i,
    input  logic           start_i,
    input  logic [RSZ-1:0] start_ptr_i,
    input  logic [RSZ:0]   len_i,
    input  logic           abort_i,
    output logic [RSZ-1:0] bram_rp_o,
    output logic           bram_ack_o,
    input  logic [DW-1:0]  bram_dat_i,
    input  logic           bram_ack_i,
    output logic [DW-1:0]  dat_o,
    output logic           val_o,
    input  logic           rdy_i,
    output logic           last_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    localparam logic [7:0] TLOAD = 8'(TOUT);

    state_t         st, st_n;
    logic [RSZ:0]   rem, rem_n;
    logic [7:0]     tcnt, tcnt_n;
    logic           abt, abt_n;
    logic [RSZ-1:0] rp_n;
    logic           req_n, busy_n, done_n, err_n;
    logic           push, flush, pop;
    logic           drained, tail;
    logic [DW-1:0]  sdat;
    logic           slast, sval;

    assign pop  = val_o & rdy_i;
    assign tail = (rem == (RSZ+1)'(1));
    // buffer holds nothing after this cycle's pop
    assign drained = !val_o || (!sval && rdy_i);

    always_comb begin
        st_n   = st;
        rp_n   = bram_rp_o;
        rem_n  = rem;
        tcnt_n = tcnt;
        abt_n  = abt;
        req_n  = 1'b0;
        busy_n = busy_o;
        done_n = 1'b0;
        err_n  = err_o;
        push   = 1'b0;
        flush  = 1'b0;
        unique case (st)
            IDLE: begin
                if (start_i) begin
                    err_n = 1'b0;
                    if (len_i != '0) begin
                        rp_n   = start_ptr_i;
                        rem_n  = len_i;
                        busy_n = 1'b1;
                        abt_n  = 1'b0;
                        req_n  = 1'b1;
                        tcnt_n = TLOAD;
                        st_n   = REQ;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bram_ack_o) begin
                    // request is out: its acknowledge must be absorbed in WAIT
                    tcnt_n = tcnt - 8'd1;
                    st_n   = WAIT;
                    if (abort_i) begin
                        abt_n = 1'b1;
                        flush = 1'b1;
                    end
                end else if (abort_i) begin
                    flush  = 1'b1;
                    busy_n = 1'b0;
                    st_n   = IDLE;
                end else if (!(sval && !rdy_i)) begin
                    req_n  = 1'b1;
                    tcnt_n = TLOAD;
                end
            end
            WAIT: begin
                if (abort_i) begin
                    abt_n = 1'b1;
                    flush = 1'b1;
                end
                if (bram_ack_i) begin
                    if (abt || abort_i) begin
                        abt_n  = 1'b0;
                        busy_n = 1'b0;
                        st_n   = IDLE;
                    end else begin
                        push  = 1'b1;
                        rp_n  = bram_rp_o + 1'b1;
                        rem_n = rem - 1'b1;
                        if (tail) begin
                            st_n = DRAIN;
                        end else begin
                            st_n   = REQ;
                            req_n  = drained;
                            tcnt_n = TLOAD;
                        end
                    end
                end else if (tcnt <= 8'd1) begin
                    err_n  = 1'b1;
                    flush  = 1'b1;
                    abt_n  = 1'b0;
                    busy_n = 1'b0;
                    st_n   = IDLE;
                end else begin
                    tcnt_n = tcnt - 8'd1;
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    flush  = 1'b1;
                    busy_n = 1'b0;
                    st_n   = IDLE;
                end else if (drained) begin
                    done_n = 1'b1;
                    busy_n = 1'b0;
                    st_n   = IDLE;
                end
            end
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            st         <= IDLE;
            rem        <= '0;
            tcnt       <= '0;
            abt        <= 1'b0;
            bram_rp_o  <= '0;
            bram_ack_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            st         <= st_n;
            rem        <= rem_n;
            tcnt       <= tcnt_n;
            abt        <= abt_n;
            bram_rp_o  <= rp_n;
            bram_ack_o <= req_n;
            busy_o     <= busy_n;
            done_o     <= done_n;
            err_o      <= err_n;
        end
    end

    // head register drives the stream, second slot is the skid entry
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            dat_o  <= '0;
            last_o <= 1'b0;
            val_o  <= 1'b0;
            sdat   <= '0;
            slast  <= 1'b0;
            sval   <= 1'b0;
        end else if (flush) begin
            val_o  <= 1'b0;
            last_o <= 1'b0;
            sval   <= 1'b0;
        end else if (pop) begin
            if (sval) begin
                dat_o  <= sdat;
                last_o <= slast;
                sval   <= push;
                sdat   <= bram_dat_i;
                slast  <= tail;
            end else if (push) begin
                dat_o  <= bram_dat_i;
                last_o <= tail;
            end else begin
                val_o  <= 1'b0;
                last_o <= 1'b0;
            end
        end else if (push) begin
            if (val_o) begin
                sdat  <= bram_dat_i;
                slast <= tail;
                sval  <= 1'b1;
            end else begin
                dat_o  <= bram_dat_i;
                last_o <= tail;
                val_o  <= 1'b1;
            end
        end
    end

endmodule

// File: doc/rp_acq_bram_rd.md
Name: rp_acq_bram_rd

Overview:
- Burst read agent that drains samples from the acquisition sample buffer through its read port (read pointer, request strobe, data, delayed acknowledge).
- Issues one read per sample and holds the pointer stable until the buffer's acknowledge returns, then captures the data.
- Pushes samples into a 2-entry output buffer that feeds a valid/ready stream toward the readout/DMA side.
- Handles wrap-around of the circular buffer, burst length, abort and acknowledge timeout.

Parameters:
DW, 14, sample data width
RSZ, 14, buffer address width; buffer depth = 2^RSZ
TOUT, 15, cycles to wait for acknowledge before declaring error (1..255)

Ports:
adc_clk_i  input  1  ADC clock; all logic on rising edge
adc_rstn_i  input  1  asynchronous active-low reset
start_i  input  1  burst start pulse; accepted only in IDLE
start_ptr_i  input  RSZ  first buffer address of burst
len_i  input  RSZ+1  sample count, 0..2^RSZ
abort_i  input  1  terminate burst
bram_rp_o  output  RSZ  read address to buffer
bram_ack_o  output  1  single-cycle read request strobe to buffer
bram_dat_i  input  DW  read data from buffer
bram_ack_i  input  1  delayed acknowledge from buffer; data valid while high
dat_o  output  DW  stream data
val_o  output  1  stream valid
rdy_i  input  1  stream ready; transfer when val_o and rdy_i are both high
last_o  output  1  marks final sample of burst, qualified by val_o
busy_o  output  1  burst in progress
done_o  output  1  one-cycle pulse after last sample transferred
err_o  output  1  sticky timeout flag; cleared by next accepted start_i

Behaviour:
- Reset values: bram_rp_o=0, bram_ack_o=0, dat_o=0, val_o=0, last_o=0, busy_o=0, done_o=0, err_o=0, FSM=IDLE, FIFO empty.
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT, DRAIN.
- IDLE, start_i=1, len_i>0:
  - Latch pointer and remaining count; set busy_o; clear err_o.
  - Go to REQ.
- IDLE, start_i=1, len_i=0:
  - done_o pulses the next cycle; no request is issued; busy_o stays 0.
- REQ:
  - Enter only when FIFO occupancy is less than 2.
  - Drive bram_rp_o=pointer and bram_ack_o=1 for exactly one cycle; load the timeout counter; go to WAIT.
- WAIT:
  - bram_rp_o is held constant.
  - On bram_ack_i=1, write bram_dat_i to the FIFO with a last tag (remaining==1).
  - Increment pointer modulo 2^RSZ (wraps from 2^RSZ-1 to 0) and decrement remaining.
  - If remaining becomes 0, go to DRAIN; else go to REQ.
- Latency:
  - start_i at cycle T: bram_ack_o high at T+1; the buffer returns bram_ack_i at T+5; val_o at T+6.
  - Steady state: 5 cycles per sample when rdy_i stays high.
- DRAIN: when the FIFO is empty after the last transfer, go to IDLE, pulse done_o, clear busy_o.
- Stream: dat_o, val_o and last_o come from the FIFO head and hold stable while val_o=1 and rdy_i=0.
- FIFO full (2 entries): REQ is stalled; no request is issued until an entry pops.
- Timeout: the counter decrements each WAIT cycle. If it reaches 0 with no bram_ack_i:
  - Set err_o and flush the FIFO.
  - Go to IDLE, clear busy_o; done_o is not pulsed.
- abort_i=1 in any non-IDLE state:
  - No further requests; the FIFO is flushed; val_o=0 next cycle.
  - If in WAIT, stay until bram_ack_i (data discarded) or timeout, so a stale acknowledge cannot reach a later burst.
  - Then go to IDLE, clear busy_o; done_o is not pulsed.
- Ignored inputs:
  - start_i while busy_o=1.
  - bram_ack_i outside WAIT.
- abort_i and a final pop in the same cycle: abort wins; done_o is not pulsed.
- FIFO push and pop in the same cycle: occupancy unchanged.
- Reset asserted mid-burst: immediate return to reset values; in-flight acknowledge after release is ignored.

Test Plan:
- start_ptr=0x0010, len=4, rdy_i=1, buffer model returns addr+0x100 → dat_o 0x110,0x111,0x112,0x113 at cycles T+6, +11, +16, +21; last_o on 4th; done_o one cycle later.
- start_ptr=0x3FFE, len=4, RSZ=14 → bram_rp_o sequence 0x3FFE,0x3FFF,0x0000,0x0001.
- len=3, rdy_i=0 until 30 cycles after start → exactly 2 requests issued, third only after first pop; data order and values preserved.
- Buffer model never acknowledges, TOUT=15 → err_o set 15 cycles after bram_ack_o; busy_o low; no done_o. Next start_i clears err_o.
- abort_i during WAIT of 2nd sample, acknowledge arrives 2 cycles later → no val_o for the aborted data; IDLE after acknowledge; a new burst returns correct data.
- len_i=0 → done_o pulse, zero bram_ack_o pulses. start_i while busy → ignored; length unchanged.
